// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_ctrl : fetch sequencer (IDLE/RUN/MISS/MISS_KILL) that drives       |
// |   icache_re, stall, inst_valid and the PC override path.                 |
// |   Optional macro FETCH_PERF_EN adds miss_cycles/redirects counters.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_2000
`ifdef FETCH_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_stall,
  input  logic        interlock,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        icache_re,
  output logic        stall,
  output logic        inst_valid,
  output logic        pc_override_valid,
  output logic [31:0] pc_override
`ifdef FETCH_PERF_EN
  , output logic [CNT_W-1:0] miss_cycles
  , output logic [CNT_W-1:0] redirects
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    MISS      = 2'd2,
    MISS_KILL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    state_d           = state_q;
    target_d          = target_q;
    icache_re         = 1'b1;
    stall             = 1'b0;
    inst_valid        = 1'b0;
    pc_override_valid = 1'b0;
    pc_override       = '0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid && !icache_stall) begin
          pc_override_valid = 1'b1;
          pc_override       = redirect_target;
        end else if (redirect_valid) begin
          target_d = redirect_target;
          stall    = 1'b1;
          state_d  = MISS_KILL;
        end else if (icache_stall) begin
          stall   = 1'b1;
          state_d = MISS;
        end else if (interlock) begin
          stall = 1'b1;
        end else begin
          inst_valid = 1'b1;
        end
      end
      MISS: begin
        if (redirect_valid) begin
          target_d = redirect_target;
          stall    = 1'b1;
          state_d  = MISS_KILL;
        end else if (!icache_stall) begin
          // returning line is accepted into IF/ID, so the pipe must not freeze
          inst_valid = 1'b1;
          state_d    = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      MISS_KILL: begin
        if (redirect_valid) begin
          target_d = redirect_target;
        end
        if (!icache_stall) begin
          pc_override_valid = 1'b1;
          pc_override       = redirect_valid ? redirect_target : target_q;
          state_d           = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // IDLE output values also apply while reset is held, whatever the state
    if (!reset || state_q == IDLE) begin
      icache_re         = 1'b0;
      stall             = 1'b1;
      inst_valid        = 1'b0;
      pc_override_valid = 1'b1;
      pc_override       = PC_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef FETCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] miss_cycles_q, miss_cycles_d;
  logic [CNT_W-1:0] redirects_q, redirects_d;

  always_comb begin
    miss_cycles_d = miss_cycles_q;
    redirects_d   = redirects_q;
    if ((state_q == MISS || state_q == MISS_KILL) && miss_cycles_q != '1) begin
      miss_cycles_d = miss_cycles_q + CNT_ONE;
    end
    if (pc_override_valid && state_q != IDLE && redirects_q != '1) begin
      redirects_d = redirects_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      miss_cycles_q <= '0;
      redirects_q   <= '0;
    end else begin
      miss_cycles_q <= miss_cycles_d;
      redirects_q   <= redirects_d;
    end
  end

  assign miss_cycles = miss_cycles_q;
  assign redirects   = redirects_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_ctrl : directed bench for fetch_ctrl with a cycle model of the  |
// |   fetch rules (counters checked when FETCH_PERF_EN is defined).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_stall;
  logic        interlock;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        icache_re;
  logic        stall;
  logic        inst_valid;
  logic        pc_override_valid;
  logic [31:0] pc_override;
`ifdef FETCH_PERF_EN
  logic [31:0] miss_cycles;
  logic [31:0] redirects;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .icache_stall      (icache_stall),
    .interlock         (interlock),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .icache_re         (icache_re),
    .stall             (stall),
    .inst_valid        (inst_valid),
    .pc_override_valid (pc_override_valid),
    .pc_override       (pc_override)
`ifdef FETCH_PERF_EN
    , .miss_cycles     (miss_cycles)
    , .redirects       (redirects)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Model state: what the fetch unit is doing, in plain flags.
  bit          m_known = 0;
  bit          m_idle, m_waiting, m_killed;
  logic [31:0] m_pc;
  int unsigned m_miss_cnt, m_redir_cnt;

  always @(negedge clk) begin
    logic        e_re, e_st, e_iv, e_pov;
    logic [31:0] e_pc;
    e_re = 1'b1; e_st = 1'b0; e_iv = 1'b0; e_pov = 1'b0; e_pc = '0;
    if (!reset || m_idle) begin
      e_re = 1'b0; e_st = 1'b1; e_pov = 1'b1; e_pc = 32'h0000_2000;
    end else if (m_killed) begin
      if (!icache_stall) begin
        e_pov = 1'b1;
        e_pc  = redirect_valid ? redirect_target : m_pc;
      end else begin
        e_st = 1'b1;
      end
    end else if (m_waiting) begin
      if (redirect_valid) e_st = 1'b1;
      else if (!icache_stall) e_iv = 1'b1;
      else e_st = 1'b1;
    end else begin
      if (redirect_valid && !icache_stall) begin
        e_pov = 1'b1; e_pc = redirect_target;
      end else if (redirect_valid || icache_stall || interlock) begin
        e_st = 1'b1;
      end else begin
        e_iv = 1'b1;
      end
    end

    if (!reset) m_known = 1;
    if (m_known) begin
      chk1 ("icache_re", icache_re, e_re);
      chk1 ("stall", stall, e_st);
      chk1 ("inst_valid", inst_valid, e_iv);
      chk1 ("pc_override_valid", pc_override_valid, e_pov);
      chk32("pc_override", pc_override, e_pc);
`ifdef FETCH_PERF_EN
      chk32("miss_cycles", miss_cycles, m_miss_cnt);
      chk32("redirects", redirects, m_redir_cnt);
`endif
    end

    // advance the model to the state seen after the coming rising edge
    if (!reset) begin
      m_idle = 1; m_waiting = 0; m_killed = 0; m_pc = '0;
      m_miss_cnt = 0; m_redir_cnt = 0;
    end else begin
      if (m_waiting || m_killed) m_miss_cnt++;
      if (e_pov && !m_idle) m_redir_cnt++;
      if (m_idle) begin
        m_idle = 0;
      end else if (m_killed) begin
        if (redirect_valid) m_pc = redirect_target;
        if (!icache_stall) m_killed = 0;
      end else if (m_waiting) begin
        if (redirect_valid) begin
          m_pc = redirect_target; m_killed = 1; m_waiting = 0;
        end else if (!icache_stall) begin
          m_waiting = 0;
        end
      end else begin
        if (redirect_valid && icache_stall) begin
          m_pc = redirect_target; m_killed = 1;
        end else if (icache_stall && !redirect_valid) begin
          m_waiting = 1;
        end
      end
    end
  end

  task automatic step(input logic r, input logic ist, input logic il,
                      input logic rv, input logic [31:0] rt);
    @(posedge clk); #1;
    reset = r; icache_stall = ist; interlock = il;
    redirect_valid = rv; redirect_target = rt;
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; icache_stall = 1'b0; interlock = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;

    // reset held two cycles, then one IDLE cycle, then RUN
    step(0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h1234_5678);
    chk1 ("rst pov", pc_override_valid, 1'b1);
    chk32("rst pc", pc_override, 32'h0000_2000);
    chk1 ("rst re", icache_re, 1'b0);
    step(1, 0, 0, 0, 32'h0);
    chk1 ("idle pov", pc_override_valid, 1'b1);
    chk32("idle pc", pc_override, 32'h0000_2000);
    chk1 ("idle re", icache_re, 1'b0);
    step(1, 0, 0, 0, 32'h0);
    chk1 ("run re", icache_re, 1'b1);
    chk1 ("run iv", inst_valid, 1'b1);
    chk32("run pc zero", pc_override, 32'h0);

    // five-cycle miss, data on the sixth
    for (int i = 0; i < 5; i++) begin
      step(1, 1, (i == 2), 0, 32'h0);
      chk1("miss stall", stall, 1'b1);
      chk1("miss iv", inst_valid, 1'b0);
    end
    step(1, 0, 0, 0, 32'h0);
    chk1("miss return iv", inst_valid, 1'b1);
    chk1("miss return stall", stall, 1'b0);
    step(1, 0, 0, 0, 32'h0);
`ifdef FETCH_PERF_EN
    chk32("miss_cycles=5", miss_cycles, 32'd5);
`endif

    // redirect in RUN without a miss: same-cycle override
    step(1, 0, 0, 1, 32'h0000_2040);
    chk1 ("redir pov", pc_override_valid, 1'b1);
    chk32("redir pc", pc_override, 32'h0000_2040);
    chk1 ("redir iv", inst_valid, 1'b0);
    chk1 ("redir stall", stall, 1'b0);

    // redirect beats interlock
    step(1, 0, 1, 1, 32'h0000_2080);
    chk1 ("redir>il pov", pc_override_valid, 1'b1);
    chk1 ("redir>il stall", stall, 1'b0);
    step(1, 0, 1, 0, 32'h0);
    chk1 ("interlock stall", stall, 1'b1);
    chk1 ("interlock re", icache_re, 1'b1);

    // fresh reset, then miss with two redirects, latest wins
    step(0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 1, 1, 32'h0000_3000);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 0, 1, 32'h0000_3100);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 32'h0);
      chk1("kill pov low", pc_override_valid, 1'b0);
    end
    step(1, 0, 1, 0, 32'h0);
    chk1 ("kill pulse", pc_override_valid, 1'b1);
    chk32("kill pc", pc_override, 32'h0000_3100);
    chk1 ("kill iv", inst_valid, 1'b0);
    chk1 ("kill stall", stall, 1'b0);
    step(1, 0, 0, 0, 32'h0);
`ifdef FETCH_PERF_EN
    chk32("redirects=1", redirects, 32'd1);
`endif

    // redirect during stall in RUN, then redirect on the release cycle
    step(1, 1, 0, 1, 32'h0000_4000);
    chk1 ("run kill stall", stall, 1'b1);
    step(1, 0, 0, 0, 32'h0);
    chk32("kill latched pc", pc_override, 32'h0000_4000);
    step(1, 1, 0, 1, 32'h0000_5000);
    step(1, 0, 0, 1, 32'h0000_5100);
    chk32("kill bypass pc", pc_override, 32'h0000_5100);
    // redirect on the same cycle the miss data would return
    step(1, 1, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h0000_5200);
    chk1 ("miss redir iv", inst_valid, 1'b0);
    step(1, 0, 0, 0, 32'h0);
    chk32("miss redir pc", pc_override, 32'h0000_5200);

    // reset taken in MISS_KILL
    step(1, 1, 0, 1, 32'h0000_6000);
    step(0, 1, 0, 0, 32'h0);
    chk32("rst in kill pc", pc_override, 32'h0000_2000);
    step(1, 0, 0, 0, 32'h0);
    chk1 ("post rst idle re", icache_re, 1'b0);
    chk32("post rst idle pc", pc_override, 32'h0000_2000);
`ifdef FETCH_PERF_EN
    chk32("post rst miss_cycles", miss_cycles, 32'd0);
    chk32("post rst redirects", redirects, 32'd0);
`endif
    step(1, 0, 0, 0, 32'h0);
    chk1 ("post rst run pov", pc_override_valid, 1'b0);
    chk32("post rst run pc", pc_override, 32'h0);

    // mixed directed pattern sweep checked by the model
    for (int i = 0; i < 32; i++) begin
      step(1, i[0] ^ i[3], i[1], (i[2] && i[4]) || (i == 9), 32'h0000_7000 + 32'(i * 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
